// File: rtl/scan_ctrl_pkg.sv
// Shared types and defaults for the scan chain controller.
package scan_ctrl_pkg;

    localparam int unsigned DefChainLen = 8;
    localparam int unsigned DefCntW     = 4;

    typedef enum logic [2:0] {
        StIdle,
        StShift,
        StCapture,
        StUnload,
        StDone
    } state_e;

endpackage

// File: rtl/scan_shreg.sv
// Dual-purpose shift register: pattern leaves from the MSB while the chain response
// enters at the LSB, so after Width shifts it holds the response in MSB-first order.
module scan_shreg #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_i,
    input  logic [Width-1:0] load_val_i,
    input  logic             shift_i,
    input  logic             ser_i,
    output logic             ser_o,
    output logic [Width-1:0] par_next_o
);

    logic [Width-1:0] sh_q, sh_d;

    // Value after the pending shift, so the final serial sample is visible in parallel.
    assign par_next_o = {sh_q[Width-2:0], ser_i};
    assign ser_o      = sh_q[Width-1];

    always_comb begin
        sh_d = sh_q;
        if (load_i) begin
            sh_d = load_val_i;
        end else if (shift_i) begin
            sh_d = par_next_o;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

endmodule

// File: rtl/scan_chain_ctrl.sv
// Scan chain test controller: shift-in, capture, and overlapped shift-out of responses.
module scan_chain_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int unsigned CHAIN_LEN  = DefChainLen,
    parameter int unsigned CNT_W      = DefCntW,
    parameter int unsigned CAP_CYCLES = 1,
    parameter bit          FILL_BIT   = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset_L,
    input  logic                 start,
    input  logic [CHAIN_LEN-1:0] pat_in,
    input  logic                 pat_valid,
    output logic                 pat_ready,
    output logic                 SE,
    output logic                 SD,
    input  logic                 scan_q,
    output logic [CHAIN_LEN-1:0] resp,
    output logic                 resp_valid,
    output logic                 busy,
    output logic                 done
);

    localparam logic [CNT_W-1:0] ShiftLast = CNT_W'(CHAIN_LEN - 1);
    localparam logic [CNT_W-1:0] CapLast   = CNT_W'(CAP_CYCLES - 1);

    state_e               state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic                 first_q, first_d;
    logic                 pat_ready_q, pat_ready_d;
    logic                 se_q, se_d;
    logic [CHAIN_LEN-1:0] resp_q, resp_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 sh_load, sh_shift;
    logic [CHAIN_LEN-1:0] sh_load_val, sh_par_next;

    scan_shreg #(
        .Width (CHAIN_LEN)
    ) u_shreg (
        .clk_i      (clk),
        .rst_ni     (reset_L),
        .load_i     (sh_load),
        .load_val_i (sh_load_val),
        .shift_i    (sh_shift),
        .ser_i      (scan_q),
        .ser_o      (SD),
        .par_next_o (sh_par_next)
    );

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        first_d      = first_q;
        pat_ready_d  = 1'b0;
        resp_d       = resp_q;
        resp_valid_d = 1'b0;
        sh_load      = 1'b0;
        sh_load_val  = pat_in;
        sh_shift     = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start && pat_valid) begin
                    sh_load     = 1'b1;
                    pat_ready_d = 1'b1;
                    first_d     = 1'b1;
                    state_d     = StShift;
                end
            end
            StShift: begin
                sh_shift = 1'b1;
                if (cnt_q == ShiftLast) begin
                    cnt_d   = '0;
                    first_d = 1'b0;
                    state_d = StCapture;
                    // The first shift of a session unloads pre-session chain state.
                    if (!first_q) begin
                        resp_d       = sh_par_next;
                        resp_valid_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StCapture: begin
                if (cnt_q == CapLast) begin
                    cnt_d   = '0;
                    sh_load = 1'b1;
                    if (pat_valid) begin
                        pat_ready_d = 1'b1;
                        state_d     = StShift;
                    end else begin
                        sh_load_val = {CHAIN_LEN{FILL_BIT}};
                        state_d     = StUnload;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StUnload: begin
                sh_shift = 1'b1;
                if (cnt_q == ShiftLast) begin
                    cnt_d        = '0;
                    resp_d       = sh_par_next;
                    resp_valid_d = 1'b1;
                    state_d      = StDone;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // Outputs follow the next state so they stay aligned with it once registered.
        se_d   = (state_d == StShift) || (state_d == StUnload);
        busy_d = (state_d != StIdle);
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clk or negedge reset_L) begin
        if (!reset_L) begin
            state_q      <= StIdle;
            cnt_q        <= '0;
            first_q      <= 1'b0;
            pat_ready_q  <= 1'b0;
            se_q         <= 1'b0;
            resp_q       <= '0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            first_q      <= first_d;
            pat_ready_q  <= pat_ready_d;
            se_q         <= se_d;
            resp_q       <= resp_d;
            resp_valid_q <= resp_valid_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign pat_ready  = pat_ready_q;
    assign SE         = se_q;
    assign resp       = resp_q;
    assign resp_valid = resp_valid_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_scan_chain_ctrl.sv
// Bench for scan_chain_ctrl: two controllers (1 and 3 capture cycles) each driving an
// 8-cell chain whose capture input is the inverted cell output.
module tb_scan_chain_ctrl;

    localparam int unsigned L = 8;

    logic         clk       = 1'b0;
    logic         reset_L   = 1'b0;
    logic         start     = 1'b0;
    logic         pat_valid = 1'b0;
    logic [L-1:0] pat_in    = '0;
    logic         sel       = 1'b0;

    logic         pr_a, se_a, sd_a, rv_a, busy_a, done_a;
    logic         pr_b, se_b, sd_b, rv_b, busy_b, done_b;
    logic [L-1:0] resp_a, resp_b;
    logic [L-1:0] chain_a = '0;
    logic [L-1:0] chain_b = '0;

    logic         m_pr, m_se, m_rv, m_busy, m_done;
    logic [L-1:0] m_resp;

    int           errors = 0;
    int           checks = 0;
    int           pr_n = 0, rv_n = 0, done_n = 0, busy_n = 0, se_n = 0, cap_n = 0;
    logic [L-1:0] sb[$];
    logic [L-1:0] chain_snap;

    always #5 clk = ~clk;

    scan_chain_ctrl #(
        .CHAIN_LEN  (L),
        .CNT_W      (4),
        .CAP_CYCLES (1),
        .FILL_BIT   (1'b0)
    ) dut_a (
        .clk        (clk),
        .reset_L    (reset_L),
        .start      (start & ~sel),
        .pat_in     (pat_in),
        .pat_valid  (pat_valid & ~sel),
        .pat_ready  (pr_a),
        .SE         (se_a),
        .SD         (sd_a),
        .scan_q     (chain_a[L-1]),
        .resp       (resp_a),
        .resp_valid (rv_a),
        .busy       (busy_a),
        .done       (done_a)
    );

    scan_chain_ctrl #(
        .CHAIN_LEN  (L),
        .CNT_W      (4),
        .CAP_CYCLES (3),
        .FILL_BIT   (1'b0)
    ) dut_b (
        .clk        (clk),
        .reset_L    (reset_L),
        .start      (start & sel),
        .pat_in     (pat_in),
        .pat_valid  (pat_valid & sel),
        .pat_ready  (pr_b),
        .SE         (se_b),
        .SD         (sd_b),
        .scan_q     (chain_b[L-1]),
        .resp       (resp_b),
        .resp_valid (rv_b),
        .busy       (busy_b),
        .done       (done_b)
    );

    // Chain model: shift toward the tail when SE=1, otherwise capture D_i = ~Q_i.
    always @(posedge clk) begin
        chain_a <= se_a ? {chain_a[L-2:0], sd_a} : ~chain_a;
        chain_b <= se_b ? {chain_b[L-2:0], sd_b} : ~chain_b;
    end

    assign m_pr   = sel ? pr_b   : pr_a;
    assign m_se   = sel ? se_b   : se_a;
    assign m_rv   = sel ? rv_b   : rv_a;
    assign m_busy = sel ? busy_b : busy_a;
    assign m_done = sel ? done_b : done_a;
    assign m_resp = sel ? resp_b : resp_a;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        logic [L-1:0] exp;
        @(negedge clk);
        if (m_pr)   pr_n++;
        if (m_done) done_n++;
        if (m_busy) busy_n++;
        if (m_se)   se_n++;
        if (m_busy && !m_se && !m_done) cap_n++;
        if (m_rv) begin
            rv_n++;
            chk("sb_has_entry", 32'(sb.size() > 0), 32'd1);
            if (sb.size() > 0) begin
                exp = sb.pop_front();
                chk("resp", 32'(m_resp), 32'(exp));
            end
        end
    endtask

    task automatic session(input int n, input logic [L-1:0] p0, input logic [L-1:0] p1,
                           input logic [L-1:0] p2, input bit hold_start);
        logic [L-1:0] pv[3];
        bit           seen;
        pv[0] = p0;
        pv[1] = p1;
        pv[2] = p2;
        pat_in    = pv[0];
        pat_valid = 1'b1;
        start     = 1'b1;
        for (int k = 0; k < n; k++) begin
            seen = 1'b0;
            for (int c = 0; c < 100 && !seen; c++) begin
                tick();
                seen = m_pr;
            end
            chk("pat_ready_seen", 32'(seen), 32'd1);
            sb.push_back(~pv[k]);
            start = hold_start;
            if (k + 1 < n) pat_in = pv[k+1];
            else pat_valid = 1'b0;
        end
        seen = 1'b0;
        for (int c = 0; c < 100 && !seen; c++) begin
            tick();
            seen = m_done;
        end
        chain_snap = sel ? chain_b : chain_a;
        start = 1'b0;
        chk("done_seen", 32'(seen), 32'd1);
    endtask

    initial begin
        int  pr0, rv0, dn0, bz0, se0, cp0;
        bit  seen;

        @(negedge clk);
        chk("reset_a", 32'({pr_a, se_a, sd_a, rv_a, busy_a, done_a, resp_a}), 32'd0);
        chk("reset_b", 32'({pr_b, se_b, sd_b, rv_b, busy_b, done_b, resp_b}), 32'd0);
        reset_L = 1'b1;
        tick();

        // Abort mid-shift: reset lands during the 4th shift cycle.
        pat_in = 8'hA5; pat_valid = 1'b1; start = 1'b1;
        seen = 1'b0;
        for (int c = 0; c < 20 && !seen; c++) begin
            tick();
            seen = m_pr;
        end
        chk("abort_accept", 32'(seen), 32'd1);
        start = 1'b0; pat_valid = 1'b0;
        repeat (3) tick();
        chk("abort_in_shift", 32'({m_se, m_busy}), 32'b11);
        #2 reset_L = 1'b0;
        #1 chk("abort_outs", 32'({pr_a, se_a, sd_a, rv_a, busy_a, done_a, resp_a}), 32'd0);
        @(negedge clk);
        reset_L = 1'b1;
        tick();

        // Start without a valid pattern is dropped.
        pr0 = pr_n; bz0 = busy_n;
        start = 1'b1;
        repeat (3) tick();
        start = 1'b0;
        tick();
        chk("nostart_ready", 32'(pr_n - pr0), 32'd0);
        chk("nostart_busy", 32'(busy_n - bz0), 32'd0);

        // Single pattern A5 -> 5A.
        pr0 = pr_n; rv0 = rv_n; dn0 = done_n; bz0 = busy_n; se0 = se_n; cp0 = cap_n;
        session(1, 8'hA5, 8'h00, 8'h00, 1'b0);
        chk("a5_ready_n", 32'(pr_n - pr0), 32'd1);
        chk("a5_rv_n", 32'(rv_n - rv0), 32'd1);
        chk("a5_done_n", 32'(done_n - dn0), 32'd1);
        chk("a5_busy_n", 32'(busy_n - bz0), 32'd18);
        chk("a5_se_n", 32'(se_n - se0), 32'd16);
        chk("a5_cap_n", 32'(cap_n - cp0), 32'd1);
        chk("a5_sb_empty", 32'(sb.size()), 32'd0);
        tick();

        // Back-to-back 0F, C3, FF -> F0, 3C, 00.
        pr0 = pr_n; rv0 = rv_n; dn0 = done_n;
        session(3, 8'h0F, 8'hC3, 8'hFF, 1'b0);
        chk("b2b_ready_n", 32'(pr_n - pr0), 32'd3);
        chk("b2b_rv_n", 32'(rv_n - rv0), 32'd3);
        chk("b2b_done_n", 32'(done_n - dn0), 32'd1);
        chk("b2b_sb_empty", 32'(sb.size()), 32'd0);
        tick();

        // 81 -> 7E with start held high while busy; chain left all fill bits.
        pr0 = pr_n; rv0 = rv_n; dn0 = done_n;
        session(1, 8'h81, 8'h00, 8'h00, 1'b1);
        chk("unload_chain_fill", 32'(chain_snap), 32'h00);
        chk("unload_ready_n", 32'(pr_n - pr0), 32'd1);
        chk("unload_rv_n", 32'(rv_n - rv0), 32'd1);
        tick();
        bz0 = busy_n;
        repeat (5) tick();
        chk("busy_start_ignored", 32'(busy_n - bz0), 32'd0);
        chk("unload_done_n", 32'(done_n - dn0), 32'd1);

        // Three capture cycles: 3C -> C3.
        sel = 1'b1;
        tick();
        rv0 = rv_n; se0 = se_n; cp0 = cap_n; bz0 = busy_n;
        session(1, 8'h3C, 8'h00, 8'h00, 1'b0);
        chk("cap3_cap_n", 32'(cap_n - cp0), 32'd3);
        chk("cap3_se_n", 32'(se_n - se0), 32'd16);
        chk("cap3_busy_n", 32'(busy_n - bz0), 32'd20);
        chk("cap3_rv_n", 32'(rv_n - rv0), 32'd1);
        chk("cap3_sb_empty", 32'(sb.size()), 32'd0);
        repeat (2) tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
